slice_serial_addsub_ctrl: RTL and testbench
===========================================

// Module: slice_serial_addsub_ctrl
// PURPOSE
//  Sequences one 4-bit ripple add/sub slice (full_adder x4) over NSLICE cycles to add or
//  subtract WIDTH-bit operands, LSB slice first, with a registered inter-slice carry.
//  Sits between an operand producer (valid/ready) and a result consumer (valid/ready).
//  Area-saving alternative to a full WIDTH-bit ripple adder.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of 4, >= 8
//  NSLICE  WIDTH/4 (derived localparam, not overridable)  slices per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand handshake valid
//  in_ready   out  1      operand handshake ready
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sub     in   1      0: A+B, 1: A-B (A + ~B + 1)
//  out_valid  out  1      result handshake valid
//  out_ready  in   1      result handshake ready
//  out_res    out  WIDTH  result, modulo 2^WIDTH
//  out_cout   out  1      carry out of MSB; for subtract 1 = no borrow (A >= B unsigned)
//  out_ovf    out  1      signed two's-complement overflow
// BEHAVIOUR
//  - One clock domain (clk); reset asynchronous, active-low; no synchronous reset path.
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, out_res=0, out_cout=0, out_ovf=0,
//    slice index=0, carry reg=0.
//  - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after slice NSLICE-1;
//    DONE -> IDLE on out_valid&&out_ready. No other transitions.
//  - IDLE: in_ready=1. On accept, latch in_a, in_b, in_sub; carry reg <= in_sub;
//    idx <= 0. Operand inputs ignored outside accept cycle.
//  - RUN: in_ready=0. Each cycle: slice k = idx; b' = in_sub ? ~B[4k+3:4k] : B[4k+3:4k];
//    {c,s} = A[4k+3:4k] + b' + carry; res[4k+3:4k] <= s; carry <= c; idx <= idx+1.
//    Exactly NSLICE RUN cycles.
//  - Final slice: out_cout <= carry out of bit WIDTH-1;
//    out_ovf <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
//  - DONE: out_valid=1, out_res/out_cout/out_ovf stable and held until out_ready.
//    in_ready=0 throughout DONE, so no new operand is accepted in that state.
//  - Latency: accept at edge N -> out_valid high after edge N+NSLICE (NSLICE+1 cycles
//    accept-to-valid). Throughput is one op per NSLICE+2 cycles with out_ready tied high.
//  - The same edge is never both a result accept and an operand accept (DONE -> IDLE first).
//  - out_res is updated only during RUN; its value in IDLE is the last result (not cleared).
//  - Wrap-around: results are modulo 2^WIDTH and out_cout flags the wrap.
//  - Reset mid-RUN or mid-DONE: abort immediately, return to reset values; the pending
//    result is lost and no out_valid is produced.
//  - in_valid dropping during RUN has no effect (operands already latched).
// TESTING (WIDTH=16)
//  1. A=5,B=3,sub=1 -> after 5 cycles out_res=0x0002, cout=1, ovf=0.
//  2. A=0,B=1,sub=1 -> out_res=0xFFFF, cout=0 (borrow), ovf=0; A=6,B=7 -> 0xFFFF, cout=0.
//  3. A=0xFFFF,B=0x0001,sub=0 -> out_res=0x0000, cout=1, ovf=0;
//     A=0x7FFF,B=1,sub=0 -> 0x8000, cout=0, ovf=1.
//  4. Backpressure: result ready, out_ready=0 for 10 cycles -> out_valid, out_res, cout and
//     ovf held; in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
//  5. Reset mid-op: assert rst_n=0 in RUN slice 2 -> same cycle out_valid=0, in_ready=1;
//     after release, the next op A=9,B=4,sub=1 -> 0x0005, cout=1.
//  6. Back-to-back, out_ready=1, in_valid=1: four ops spaced NSLICE+2 cycles apart;
//     results match a reference model; in_ready low during RUN and DONE.

Source files
------------

// File: rtl/slice_serial_addsub_ctrl.sv
// Bit-serial-by-nibble adder/subtractor: one 4-bit ripple slice reused over NSLICE cycles,
// LSB slice first, with the inter-slice carry held in a register between cycles.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module slice_serial_addsub_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_cout,
   output logic             out_ovf
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [WIDTH-1:0] a_q, b_q;
   logic             sub_q, carry;
   logic [IW-1:0]    idx;
   logic [3:0]       sa, sb, ss;
   logic [4:0]       c;
   logic             last;

   // Subtraction folds into the slice as A + ~B with the initial carry preset to 1.
   assign sa   = a_q[{idx, 2'b00} +: 4];
   assign sb   = b_q[{idx, 2'b00} +: 4] ^ {4{sub_q}};
   assign c[0] = carry;
   assign last = (idx == IW'(NSLICE - 1));

   for (genvar i = 0; i < 4; i++) begin : g_fa
      full_adder u_fa (
         .a  (sa[i]),
         .b  (sb[i]),
         .ci (c[i]),
         .s  (ss[i]),
         .co (c[i+1])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry    <= 1'b0;
         idx      <= '0;
         out_res  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         a_q   <= in_a;
         b_q   <= in_b;
         sub_q <= in_sub;
         carry <= in_sub;
         idx   <= '0;
      end else if (state == RUN) begin
         out_res[{idx, 2'b00} +: 4] <= ss;
         carry <= c[4];
         idx   <= idx + 1'b1;
         // On the top slice c[3] is the carry into bit WIDTH-1.
         if (last) begin
            out_cout <= c[4];
            out_ovf  <= c[3] ^ c[4];
         end
      end
   end

endmodule

// File: tb/tb_slice_serial_addsub_ctrl.sv
// Scoreboard bench for slice_serial_addsub_ctrl: directed vectors push expectations into
// a queue, and a negedge monitor pops and compares on each result handshake.

module tb_slice_serial_addsub_ctrl;
   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic             clk, rst_n;
   logic             in_valid, in_ready, in_sub;
   logic [WIDTH-1:0] in_a, in_b;
   logic             out_valid, out_ready, out_cout, out_ovf;
   logic [WIDTH-1:0] out_res;

   exp_t sb_q[$];
   int   nvec = 0;
   int   nerr = 0;
   time  t_acc[4];

   slice_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Independent reference: plain WIDTH+1-bit arithmetic.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sub);
      exp_t             e;
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   sum;
      bb     = sub ? ~b : b;
      sum    = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
      e.res  = sum[WIDTH-1:0];
      e.cout = sum[WIDTH];
      e.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (e.res[WIDTH-1] != a[WIDTH-1]);
      return e;
   endfunction

   // Returns #1 after the accept edge; hold keeps in_valid asserted afterwards.
   task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                        input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                        input bit push, input bit hold);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         nvec++;
         nerr++;
         $display("FAIL in_ready_timeout: got 0, expected 1");
      end
      in_a     = a;
      in_b     = b;
      in_sub   = sub;
      in_valid = 1'b1;
      e.res  = er;
      e.cout = ec;
      e.ovf  = eo;
      if (push) sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk("drain", sb_q.size(), 0);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) chk("in_ready_in_done", in_ready, 1'b0);
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_result: got res 0x%0h, expected no result", out_res);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("res",  out_res,  e.res);
            chk("cout", out_cout, e.cout);
            chk("ovf",  out_ovf,  e.ovf);
         end
      end
   end

   initial begin
      exp_t m;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready",  in_ready,  1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_res",       out_res,   16'h0);
      chk("rst_cout",      out_cout,  1'b0);
      chk("rst_ovf",       out_ovf,   1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // 5 - 3 with latency check: valid only after NSLICE RUN edges
      do_op(16'd5, 16'd3, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < NSLICE; i++) begin
         @(negedge clk);
         chk("lat_no_valid", out_valid, 1'b0);
         chk("lat_no_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      chk("lat_valid", out_valid, 1'b1);
      wait_drain();

      // Borrow and wrap cases
      do_op(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_drain();
      do_op(16'h0006, 16'h0007, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_drain();
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_drain();
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_drain();

      // Backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      do_op(16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (NSLICE) @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_res",   out_res,   16'h1234);
         chk("bp_cout",  out_cout,  1'b0);
         chk("bp_ovf",   out_ovf,   1'b0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_ready", in_ready,  1'b1);
      chk("bp_idle_valid", out_valid, 1'b0);
      chk("bp_res_kept",   out_res,   16'h1234);
      wait_drain();

      // Reset during RUN slice 2: result discarded
      do_op(16'h1234, 16'h1111, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_ready", in_ready,  1'b1);
      chk("mid_rst_res",   out_res,   16'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_no_valid", out_valid, 1'b0);
      do_op(16'd9, 16'd4, 1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b0);
      wait_drain();

      // Back-to-back with in_valid held high
      for (int k = 0; k < 4; k++) begin
         logic [WIDTH-1:0] a, b;
         logic             s;
         case (k)
            0: begin a = 16'h1234; b = 16'h4321; s = 1'b0; end
            1: begin a = 16'h8000; b = 16'h0001; s = 1'b1; end
            2: begin a = 16'hABCD; b = 16'hABCD; s = 1'b1; end
            default: begin a = 16'h8000; b = 16'h8000; s = 1'b0; end
         endcase
         m = model(a, b, s);
         do_op(a, b, s, m.res, m.cout, m.ovf, 1'b1, 1'b1);
         t_acc[k] = $time;
         if (k > 0) chk("b2b_spacing", 32'(t_acc[k] - t_acc[k-1]), 32'((NSLICE + 2) * 10));
         @(negedge clk);
         chk("b2b_ready_run", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      wait_drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
